// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_t;

   localparam logic BANK_INSTR = 1'b0;
   localparam logic BANK_DATA  = 1'b1;
   localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/mem_bank.sv
// Word RAM: combinational read, synchronous write. Contents are never reset.
module mem_bank #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   // write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Responder end of the core memory interface: edge-triggered request
// acceptance, WAIT_STATES idle cycles, one-cycle ready/err response,
// and an instruction-bank preload port.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       add,
   input  logic              read,
   input  logic              write,
   input  logic              i_ou_d,
   input  logic [31:0]       wdata,
   output logic [31:0]       out,
   output logic              ready,
   output logic              err,
   output logic              busy,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [31:0]       prog_data
);

   localparam int OFS_W = $clog2(WORD_BYTES);

   mem_state_t        state, state_nxt;
   logic [3:0]        wait_cnt, wait_cnt_nxt;
   logic              strobe, strobe_q, accept, resp_go;
   logic [31:0]       add_q, wdata_q;
   logic              rd_q, wr_q, sel_q;
   logic [31:0]       req_add, req_wdata;
   logic              req_rd, req_wr, req_sel, req_err;
   logic [ADDR_W-1:0] req_idx;
   logic              data_we, instr_core_we, instr_we;
   logic [ADDR_W-1:0] instr_waddr;
   logic [31:0]       instr_wdata, instr_rdata, data_rdata;

   function automatic logic req_error(input logic [31:0] a, input logic rd,
                                      input logic wr, input logic sel);
      logic misaligned, out_of_range;
      misaligned   = (a[OFS_W-1:0] != '0);
      out_of_range = ((a >> (ADDR_W + OFS_W)) != 32'd0);
      return misaligned | out_of_range | (wr & (sel == BANK_INSTR)) | (rd & wr);
   endfunction

   assign strobe = read | write;
   assign accept = (state == IDLE) & strobe & ~strobe_q;
   assign busy   = (state != IDLE);

   // In IDLE a zero-wait response happens on the accepting edge itself, so the
   // live inputs are used; afterwards the latched copy is authoritative.
   assign req_add   = (state == IDLE) ? add    : add_q;
   assign req_wdata = (state == IDLE) ? wdata  : wdata_q;
   assign req_rd    = (state == IDLE) ? read   : rd_q;
   assign req_wr    = (state == IDLE) ? write  : wr_q;
   assign req_sel   = (state == IDLE) ? i_ou_d : sel_q;
   assign req_idx   = req_add[ADDR_W+OFS_W-1:OFS_W];
   assign req_err   = req_error(req_add, req_rd, req_wr, req_sel);

   // Writes landing on a reset edge are dropped.
   assign data_we       = rst_n & resp_go & req_wr & ~req_err & (req_sel == BANK_DATA);
   assign instr_core_we = rst_n & resp_go & req_wr & ~req_err & (req_sel == BANK_INSTR);
   assign instr_we      = (rst_n & prog_we) | instr_core_we;
   assign instr_waddr   = prog_we ? prog_addr : req_idx;
   assign instr_wdata   = prog_we ? prog_data : req_wdata;

   // next-state, wait counting and response strobe
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      resp_go      = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_nxt = RESP;
                  resp_go   = 1'b1;
               end else begin
                  state_nxt    = WAIT;
                  wait_cnt_nxt = '0;
               end
            end
         end
         WAIT: begin
            if ({28'd0, wait_cnt} == 32'(WAIT_STATES - 1)) begin
               state_nxt = RESP;
               resp_go   = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 4'd1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // control state and strobe history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         strobe_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         strobe_q <= strobe;
      end
   end

   // request capture at acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         add_q   <= add;
         wdata_q <= wdata;
         rd_q    <= read;
         wr_q    <= write;
         sel_q   <= i_ou_d;
      end
   end

   // response registers: ready/err pulse and held read data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready <= 1'b0;
         err   <= 1'b0;
         out   <= '0;
      end else begin
         ready <= resp_go;
         err   <= resp_go & req_err;
         if (resp_go & req_rd & ~req_err)
            out <= (req_sel == BANK_DATA) ? data_rdata : instr_rdata;
      end
   end

   mem_bank #(.ADDR_W(ADDR_W)) u_instr (
      .clk   (clk),
      .we    (instr_we),
      .waddr (instr_waddr),
      .wdata (instr_wdata),
      .raddr (req_idx),
      .rdata (instr_rdata)
   );

   mem_bank #(.ADDR_W(ADDR_W)) u_data (
      .clk   (clk),
      .we    (data_we),
      .waddr (req_idx),
      .wdata (req_wdata),
      .raddr (req_idx),
      .rdata (data_rdata)
   );

endmodule
